// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register, skid buffer and redirect handling
// Optional BRANCH_DELAY_SLOT_EN: deliver the redirected capture as a delay slot instead of squashing it.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        z_flag,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] skid_data;
    logic [31:0] pend_target;
    logic [31:0] target;
    logic [31:0] fetch_data;
    logic        pend_valid;
    logic        redirect;
    logic        capture;
    logic        skid_load;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;
    assign redirect  = jump | (branch & z_flag);
    assign target    = jump ? {if_pc4[31:28], jump_index, 2'b00} : branch_target;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        skid_load  = 1'b0;
        fetch_data = imem_data;
        case (state)
            IDLE: state_next = WAIT;
            WAIT: begin
                if (imem_ready) begin
                    if (stall) begin
                        skid_load  = 1'b1;
                        state_next = HELD;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            HELD: begin
                fetch_data = skid_data;
                if (!stall) begin
                    capture    = 1'b1;
                    state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            skid_data   <= 32'd0;
            if_valid    <= 1'b0;
            if_instr    <= 32'd0;
            if_pc4      <= 32'd0;
        end else begin
            if (skid_load) skid_data <= imem_data;
            if (capture) begin
                if (redirect || pend_valid) begin
                    // A redirect seen this cycle is newer than any pending one.
                    pc         <= redirect ? target : pend_target;
                    pend_valid <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                    if_valid   <= 1'b1;
                    if_instr   <= fetch_data;
                    if_pc4     <= pc4;
`else
                    if_valid   <= 1'b0;
`endif
                end else begin
                    pc       <= pc4;
                    if_valid <= 1'b1;
                    if_instr <= fetch_data;
                    if_pc4   <= pc4;
                end
            end else begin
                if (redirect) begin
                    pend_valid  <= 1'b1;
                    pend_target <= target;
                end
                if (!stall) if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hazard hold from decode; freezes IF/ID outputs.
REQ-005 SHALL have port branch, input, 1, and port z_flag, input, 1; taken branch = branch & z_flag.
REQ-006 SHALL have port branch_target, input, 32, the sign-extended, shifted offset already added to PC+4.
REQ-007 SHALL have port jump, input, 1, and port jump_index, input, 26, the J-type index field.
REQ-008 SHALL have port imem_req, output, 1, and port imem_addr, output, 32, the instruction memory request.
REQ-009 SHALL have port imem_ready, input, 1, and port imem_data, input, 32, the memory response; data is valid only when ready=1.
REQ-010 SHALL have ports if_instr, output, 32; if_pc4, output, 32; if_valid, output, 1; these form the IF/ID register.

Function
REQ-011 SHALL implement states IDLE, WAIT and HELD; imem_req=1 only in WAIT, and imem_addr=pc in all states.
REQ-012 SHALL go IDLE->WAIT unconditionally after one cycle.
REQ-013 SHALL treat a rising edge in WAIT with imem_ready=1 and stall=0 as a capture; the state remains WAIT.
REQ-014 SHALL, in WAIT with imem_ready=1 and stall=1, store imem_data in a skid buffer, go to HELD, and leave if_* unchanged.
REQ-015 SHALL, in HELD with stall=0, capture from the skid buffer and return to WAIT; HELD with stall=1 holds everything.
REQ-016 SHALL compute redirect = jump | (branch & z_flag); jump has priority, with target {if_pc4[31:28], jump_index, 2'b00}; otherwise target = branch_target.
REQ-017 SHALL register a redirect as pending (pend_valid, pend_target) in any state, regardless of stall; a newer redirect overwrites the pending one.
REQ-018 SHALL, on a normal capture (no pending redirect and no redirect this cycle): if_instr<=data, if_pc4<=pc+4, if_valid<=1, pc<=pc+4.
REQ-019 SHALL, on a capture with a redirect this cycle or pending: pc<=target (this-cycle redirect wins over pending), clear pend_valid, and handle the instruction per REQ-027/028.
REQ-020 SHALL, on any cycle with stall=0 and no capture, set if_valid<=0 and hold if_instr and if_pc4; with stall=1, all of if_* hold.
REQ-021 SHALL compute pc+4 modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-022 SHALL give latency of one rising edge from imem_ready=1 (stall=0) to if_valid=1.

Reset
REQ-023 SHALL, when reset=1 at an edge, set state=IDLE, pc=RESET_PC, pend_valid=0, skid buffer empty, if_valid=0, if_instr=0, if_pc4=0; imem_req SHALL then be 0.
REQ-024 SHALL give reset priority over all inputs, including an imem_ready, stall or redirect in the same cycle.
REQ-025 SHALL discard any in-flight request or held data when reset is asserted mid-operation; no late response is captured.

Configuration
REQ-026 SHALL honour the macro BRANCH_DELAY_SLOT_EN.
REQ-027 SHALL, with BRANCH_DELAY_SLOT_EN undefined, squash a redirected capture: if_valid<=0, with if_instr and if_pc4 unchanged.
REQ-028 SHALL, with BRANCH_DELAY_SLOT_EN defined, deliver a redirected capture as a delay slot (if_valid<=1, if_instr<=data, if_pc4<=old pc+4) before fetching the target.

Verification
REQ-029 SHALL check reset with RESET_PC=32'h0040_0000 and imem_ready=1 every cycle -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; if_valid first rises 2 edges after reset drops.
REQ-030 SHALL check stall during fetch: ready with data=0x8C010004 while stall=1 -> if_* unchanged and imem_req=0; stall drops -> if_instr=0x8C010004 one edge later.
REQ-031 SHALL check a taken branch: branch=1, z_flag=1, branch_target=0x00400020 -> next imem_addr=0x00400020; the instruction in flight is squashed (if_valid=0) without the macro and delivered with it.
REQ-032 SHALL check branch not taken: branch=1, z_flag=0 -> sequential fetch continues, no squash.
REQ-033 SHALL check jump over branch: jump=1, jump_index=26'h0000010, branch taken, if_pc4=0x00400008 -> target 0x00000040.
REQ-034 SHALL check wrap and reset: pc=0xFFFFFFFC captured -> if_pc4=0 and next address 0; reset asserted in WAIT with ready=1 -> if_valid=0 and pc=RESET_PC.
